// File: rtl/cla_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cla_seq_ctrl
//
// Purpose:
//   Sequential WIDTH-bit add/subtract built on one shared 4-bit carry-lookahead
//   slice. Operands are latched on an accepted start. The slice is then stepped
//   one nibble per clock, least-significant nibble first, with the carry kept
//   in a register between steps. A one-cycle done pulse marks the result.
//   WIDTH = 4*NIBBLES, with NIBBLES in 1..16.
//
// Ports of cla_seq_ctrl:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   request, honoured only in IDLE or DONE
//   a, b      in   WIDTH-bit operands, latched on accepted start
//   cin       in   carry-in for add (ignored when sub=1)
//   sub       in   1 = a-b, 0 = a+b+cin
//   busy      out  high while nibbles are being processed
//   done      out  one-cycle pulse when the result is ready
//   sum       out  registered WIDTH-bit result, held until next accepted start
//   cout      out  final carry (for subtract, 1 = no borrow)
//   overflow  out  signed two's-complement overflow
//
// Ports of cla_4bit:
//   a_i, b_i  in   4-bit slice operands
//   cin_i     in   slice carry-in
//   sum_o     out  4-bit slice sum
//   cout_o    out  slice carry-out
// ---------------------------------------------------------------------------

module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [3:0] carry;

    // Every carry is expanded directly from generate/propagate terms.
    // This keeps the slice flat instead of rippling through it.
    always_comb begin
        gen      = a_i & b_i;
        prop     = a_i ^ b_i;
        carry[0] = cin_i;
        carry[1] = gen[0] | (prop[0] & cin_i);
        carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin_i);
        carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & cin_i);
        cout_o   = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0])
                 | (prop[3] & prop[2] & prop[1] & prop[0] & cin_i);
        sum_o    = prop ^ carry;
    end

endmodule

module cla_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   overflow
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [IDXW-1:0]   nibIdx_q,  nibIdx_d;
    logic              carry_q,   carry_d;
    logic [WIDTH-1:0]  opA_q,     opA_d;
    logic [WIDTH-1:0]  opB_q,     opB_d;
    logic [WIDTH-1:0]  sum_q,     sum_d;
    logic              cout_q,    cout_d;
    logic              ovf_q,     ovf_d;

    logic [3:0]        sliceA;
    logic [3:0]        sliceB;
    logic [3:0]        sliceSum;
    logic              sliceCout;
    logic              accept;

    // Pick the current nibble of each latched operand for the shared slice.
    always_comb begin
        sliceA = opA_q[{nibIdx_q, 2'b00} +: 4];
        sliceB = opB_q[{nibIdx_q, 2'b00} +: 4];
    end

    cla_4bit u_slice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    // Subtraction is done as a + ~b + 1.
    // The inverted b and the forced carry-in are captured at acceptance,
    // so the RUN path is the same for add and subtract.
    always_comb begin
        state_d  = state_q;
        nibIdx_d = nibIdx_q;
        carry_d  = carry_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        accept   = start && ((state_q == IDLE) || (state_q == DONE));

        case (state_q)
            RUN: begin
                sum_d[{nibIdx_q, 2'b00} +: 4] = sliceSum;
                carry_d = sliceCout;
                if (nibIdx_q == LAST_IDX) begin
                    cout_d  = sliceCout;
                    // Both operand signs agree, but the result sign differs.
                    ovf_d   = (opA_q[WIDTH-1] == opB_q[WIDTH-1])
                           && (sliceSum[3] != opA_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    nibIdx_d = nibIdx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            opA_d    = a;
            opB_d    = sub ? ~b : b;
            carry_d  = sub ? 1'b1 : cin;
            nibIdx_d = '0;
            sum_d    = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
            state_d  = RUN;
        end
    end

    // State and datapath registers.
    // A reset discards any partial operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            nibIdx_q <= '0;
            carry_q  <= 1'b0;
            opA_q    <= '0;
            opB_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nibIdx_q <= nibIdx_d;
            carry_q  <= carry_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Outputs come from registers or state decode only.
    always_comb begin
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        sum      = sum_q;
        cout     = cout_q;
        overflow = ovf_q;
    end

endmodule
